// File: rtl/test_receiver_pkg.sv
// Shared definitions for the test frame sender/receiver pair: default
// ethertype and MAC, FSM state encodings and the header match helper.
package test_receiver_pkg;

    localparam logic [15:0] ETH_TYPE_DEFAULT  = 16'h88B5;
    localparam logic [47:0] LOCAL_MAC_DEFAULT = 48'h02_00_00_00_00_00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DROP  = 2'd2
    } rx_state_t;

    function automatic logic hdr_match(
        input logic [47:0] dest_mac,
        input logic [15:0] eth_type,
        input logic [47:0] local_mac,
        input logic [15:0] accept_type
    );
        return (dest_mac == local_mac) && (eth_type == accept_type);
    endfunction

endpackage

// File: rtl/test_receiver_if.sv
// Ethernet header handshake plus payload stream, as seen by the receiver.
interface test_receiver_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic                  s_eth_hdr_valid;
    logic                  s_eth_hdr_ready;
    logic [47:0]           s_eth_dest_mac;
    logic [47:0]           s_eth_src_mac;
    logic [15:0]           s_eth_type;
    logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata;
    logic                  s_eth_payload_axis_tvalid;
    logic                  s_eth_payload_axis_tready;
    logic                  s_eth_payload_axis_tlast;
    logic                  s_eth_payload_axis_tuser;

    modport master (
        output s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
        output s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
        output s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
        input  s_eth_hdr_ready, s_eth_payload_axis_tready
    );

    modport slave (
        input  s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
        input  s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
        input  s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
        output s_eth_hdr_ready, s_eth_payload_axis_tready
    );

endinterface

// File: rtl/test_pattern_check.sv
// Incrementing-pattern and frame-length checker for accepted frames.
// Flags per-beat data and length errors combinationally; the owner counts them.
module test_pattern_check #(
    parameter int LENGTH     = 512,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  beat_fire,
    input  logic [DATA_WIDTH-1:0] tdata,
    input  logic                  tlast,
    output logic                  data_err,
    output logic                  len_err,
    output logic                  frame_bad,
    output logic                  synced
);

    // Index saturates at LENGTH so an overlong frame cannot wrap back to a legal index.
    localparam int               IDX_W    = $clog2(LENGTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);
    localparam logic [IDX_W-1:0] SAT_IDX  = IDX_W'(LENGTH);

    logic [IDX_W-1:0]      beat_idx;
    logic [DATA_WIDTH-1:0] exp_data;
    logic                  synced_q;
    logic                  len_flag;
    logic                  bad_flag;

    // Per-beat error decode; only one length error is reported per frame.
    always_comb begin
        data_err  = beat_fire && synced_q && (tdata != exp_data);
        len_err   = 1'b0;
        if (beat_fire && !len_flag) begin
            if (tlast) begin
                len_err = (beat_idx != LAST_IDX);
            end else begin
                len_err = (beat_idx == LAST_IDX);
            end
        end
        frame_bad = bad_flag;
        synced    = synced_q;
    end

    // Expected value always follows the received byte, so sync load and resync are the same update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_data <= '0;
            synced_q <= 1'b0;
        end else if (clr) begin
            exp_data <= '0;
            synced_q <= 1'b0;
        end else if (beat_fire) begin
            exp_data <= tdata + DATA_WIDTH'(1);
            synced_q <= 1'b1;
        end
    end

    // Beat index and sticky per-frame error flags, cleared when the frame ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_idx <= '0;
            len_flag <= 1'b0;
            bad_flag <= 1'b0;
        end else if (beat_fire) begin
            if (tlast) begin
                beat_idx <= '0;
                len_flag <= 1'b0;
                bad_flag <= 1'b0;
            end else begin
                if (beat_idx != SAT_IDX) begin
                    beat_idx <= beat_idx + IDX_W'(1);
                end
                if (len_err) begin
                    len_flag <= 1'b1;
                end
                if (data_err || len_err) begin
                    bad_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/test_receiver.sv
// Test frame receiver: header filter FSM, frame/error statistics and sync status.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a header (hdr_ready high once out of reset)
// ST_CHECK | accepted frame, payload checked against the running pattern
// ST_DROP  | rejected frame, payload consumed without any checking
module test_receiver
    import test_receiver_pkg::*;
#(
    parameter int          LENGTH     = 512,
    parameter logic [47:0] LOCAL_MAC  = LOCAL_MAC_DEFAULT,
    parameter logic [15:0] ETH_TYPE   = ETH_TYPE_DEFAULT,
    parameter int          DATA_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    test_receiver_if.slave  s_eth,
    output logic [31:0]     frame_count,
    output logic [31:0]     good_count,
    output logic [31:0]     drop_count,
    output logic [31:0]     data_err_count,
    output logic [31:0]     len_err_count,
    output logic [31:0]     user_err_count,
    output logic            synced,
    output logic [47:0]     last_src_mac
);

    rx_state_t state_q, state_d;
    logic      run_q;
    logic      hdr_ok;
    logic      hdr_fire;
    logic      check_fire;
    logic      last_fire;
    logic      data_err;
    logic      len_err;
    logic      frame_bad;

    assign hdr_ok     = hdr_match(s_eth.s_eth_dest_mac, s_eth.s_eth_type, LOCAL_MAC, ETH_TYPE);
    assign hdr_fire   = s_eth.s_eth_hdr_valid && s_eth.s_eth_hdr_ready;
    assign check_fire = s_eth.s_eth_payload_axis_tvalid && s_eth.s_eth_payload_axis_tready
                        && (state_q == ST_CHECK);
    assign last_fire  = check_fire && s_eth.s_eth_payload_axis_tlast;

    // State register; run_q holds hdr_ready low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // Next-state and handshake readies.
    always_comb begin
        state_d                         = state_q;
        s_eth.s_eth_hdr_ready           = 1'b0;
        s_eth.s_eth_payload_axis_tready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_eth.s_eth_hdr_ready = run_q;
                if (s_eth.s_eth_hdr_valid && run_q) begin
                    state_d = hdr_ok ? ST_CHECK : ST_DROP;
                end
            end
            ST_CHECK, ST_DROP: begin
                s_eth.s_eth_payload_axis_tready = 1'b1;
                if (s_eth.s_eth_payload_axis_tvalid && s_eth.s_eth_payload_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    test_pattern_check #(
        .LENGTH     (LENGTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_check (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .beat_fire (check_fire),
        .tdata     (s_eth.s_eth_payload_axis_tdata),
        .tlast     (s_eth.s_eth_payload_axis_tlast),
        .data_err  (data_err),
        .len_err   (len_err),
        .frame_bad (frame_bad),
        .synced    (synced)
    );

    // Statistics counters; clr wins over any increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count    <= '0;
            good_count     <= '0;
            drop_count     <= '0;
            data_err_count <= '0;
            len_err_count  <= '0;
            user_err_count <= '0;
        end else if (clr) begin
            frame_count    <= '0;
            good_count     <= '0;
            drop_count     <= '0;
            data_err_count <= '0;
            len_err_count  <= '0;
            user_err_count <= '0;
        end else begin
            if (hdr_fire && !hdr_ok) begin
                drop_count <= drop_count + 32'd1;
            end
            if (data_err) begin
                data_err_count <= data_err_count + 32'd1;
            end
            if (len_err) begin
                len_err_count <= len_err_count + 32'd1;
            end
            if (last_fire) begin
                frame_count <= frame_count + 32'd1;
                if (s_eth.s_eth_payload_axis_tuser) begin
                    user_err_count <= user_err_count + 32'd1;
                end
                if (!(frame_bad || data_err || len_err || s_eth.s_eth_payload_axis_tuser)) begin
                    good_count <= good_count + 32'd1;
                end
            end
        end
    end

    // Source MAC of the most recently accepted frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_src_mac <= '0;
        end else if (hdr_fire && hdr_ok) begin
            last_src_mac <= s_eth.s_eth_src_mac;
        end
    end

endmodule

// File: tb/tb_test_receiver.sv
// Directed bench for test_receiver with default parameters.
module tb_test_receiver;
    import test_receiver_pkg::*;

    localparam int          LENGTH  = 512;
    localparam logic [47:0] MAC     = 48'h02_00_00_00_00_00;
    localparam logic [47:0] BAD_MAC = 48'h02_00_00_00_00_01;
    localparam logic [15:0] ET      = 16'h88B5;
    localparam int          TMO     = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] frame_count, good_count, drop_count;
    logic [31:0] data_err_count, len_err_count, user_err_count;
    logic        synced;
    logic [47:0] last_src_mac;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  next_byte = 8'h00;
    logic        rand_gaps = 1'b0;
    logic        stalled = 1'b0;

    test_receiver_if #(.DATA_WIDTH(8)) rx_if ();

    test_receiver dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (clr),
        .s_eth          (rx_if),
        .frame_count    (frame_count),
        .good_count     (good_count),
        .drop_count     (drop_count),
        .data_err_count (data_err_count),
        .len_err_count  (len_err_count),
        .user_err_count (user_err_count),
        .synced         (synced),
        .last_src_mac   (last_src_mac)
    );

    always #5 clk = ~clk;

    task automatic idle_cycles(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic send_hdr(input logic [47:0] dest, input logic [15:0] et, input logic [47:0] src);
        int n;
        if (rand_gaps) idle_cycles($urandom_range(0, 3));
        rx_if.s_eth_dest_mac  = dest;
        rx_if.s_eth_type      = et;
        rx_if.s_eth_src_mac   = src;
        rx_if.s_eth_hdr_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rx_if.s_eth_hdr_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (!rx_if.s_eth_hdr_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL hdr_timeout: hdr_ready=%0b after %0d cycles, want 1", rx_if.s_eth_hdr_ready, n);
        end
        @(posedge clk);
        #1;
        rx_if.s_eth_hdr_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] data, input logic last, input logic user, input logic clr_with);
        int n;
        if (rand_gaps) idle_cycles($urandom_range(0, 2));
        rx_if.s_eth_payload_axis_tdata  = data;
        rx_if.s_eth_payload_axis_tlast  = last;
        rx_if.s_eth_payload_axis_tuser  = user;
        rx_if.s_eth_payload_axis_tvalid = 1'b1;
        clr = clr_with;
        n = 0;
        @(negedge clk);
        while (!rx_if.s_eth_payload_axis_tready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n != 0) stalled = 1'b1;
        if (!rx_if.s_eth_payload_axis_tready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_timeout: tready=%0b after %0d cycles, want 1", rx_if.s_eth_payload_axis_tready, n);
        end
        @(posedge clk);
        #1;
        rx_if.s_eth_payload_axis_tvalid = 1'b0;
        rx_if.s_eth_payload_axis_tlast  = 1'b0;
        rx_if.s_eth_payload_axis_tuser  = 1'b0;
        clr = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] dest, input logic [15:0] et, input logic [47:0] src,
                              input int nbeats, input int bad_idx, input logic [7:0] bad_val,
                              input logic user_last, input logic clr_last);
        logic [7:0] d;
        logic       last;
        send_hdr(dest, et, src);
        for (int i = 0; i < nbeats; i++) begin
            d    = (i == bad_idx) ? bad_val : next_byte;
            last = (i == nbeats - 1);
            send_beat(d, last, user_last && last, clr_last && last);
            next_byte = next_byte + 8'd1;
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (rx_if.s_eth_hdr_ready !== 1'b0) begin n_bad++; $display("FAIL rst_hdr_ready: got %0b want 0", rx_if.s_eth_hdr_ready); end
        n_cmp++; if (rx_if.s_eth_payload_axis_tready !== 1'b0) begin n_bad++; $display("FAIL rst_tready: got %0b want 0", rx_if.s_eth_payload_axis_tready); end
        n_cmp++; if ({frame_count, good_count, drop_count, data_err_count, len_err_count, user_err_count} !== 192'd0) begin
            n_bad++; $display("FAIL rst_counters: got %0h %0h %0h %0h %0h %0h want all 0", frame_count, good_count, drop_count, data_err_count, len_err_count, user_err_count);
        end
        n_cmp++; if ({synced, last_src_mac} !== 49'd0) begin n_bad++; $display("FAIL rst_status: synced=%0b src=%0h want 0 0", synced, last_src_mac); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (rx_if.s_eth_hdr_ready !== 1'b0) begin n_bad++; $display("FAIL hdr_ready_pre_edge: got %0b want 0", rx_if.s_eth_hdr_ready); end
        @(posedge clk);
        #1;
        n_cmp++; if (rx_if.s_eth_hdr_ready !== 1'b1) begin n_bad++; $display("FAIL hdr_ready_post_edge: got %0b want 1", rx_if.s_eth_hdr_ready); end
    endtask

    task automatic test_good_frames();
        next_byte = 8'h00;
        for (int f = 0; f < 3; f++) send_frame(MAC, ET, 48'h0A_0B_0C_0D_0E_01 + 48'(f), LENGTH, -1, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (frame_count !== 32'd3) begin n_bad++; $display("FAIL good_frame_count: got %0d want 3", frame_count); end
        n_cmp++; if (good_count !== 32'd3) begin n_bad++; $display("FAIL good_good_count: got %0d want 3", good_count); end
        n_cmp++; if ({drop_count, data_err_count, len_err_count, user_err_count} !== 128'd0) begin
            n_bad++; $display("FAIL good_err_counts: got %0d %0d %0d %0d want 0 0 0 0", drop_count, data_err_count, len_err_count, user_err_count);
        end
        n_cmp++; if (synced !== 1'b1) begin n_bad++; $display("FAIL good_synced: got %0b want 1", synced); end
        n_cmp++; if (last_src_mac !== 48'h0A_0B_0C_0D_0E_03) begin n_bad++; $display("FAIL good_src_mac: got %0h want 0a0b0c0d0e03", last_src_mac); end
    endtask

    task automatic test_corrupt();
        do_clr();
        n_cmp++; if ({frame_count, good_count, synced} !== 65'd0) begin n_bad++; $display("FAIL clr_idle: frame=%0d good=%0d synced=%0b want 0 0 0", frame_count, good_count, synced); end
        next_byte = 8'h00;
        send_frame(MAC, ET, 48'h1, LENGTH, -1, 8'h00, 1'b0, 1'b0);
        send_frame(MAC, ET, 48'h2, LENGTH, 10, 8'h55, 1'b0, 1'b0);
        send_frame(MAC, ET, 48'h3, LENGTH, -1, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (data_err_count !== 32'd2) begin n_bad++; $display("FAIL corrupt_data_err: got %0d want 2", data_err_count); end
        n_cmp++; if (good_count !== 32'd2) begin n_bad++; $display("FAIL corrupt_good: got %0d want 2", good_count); end
        n_cmp++; if (frame_count !== 32'd3) begin n_bad++; $display("FAIL corrupt_frames: got %0d want 3", frame_count); end
        n_cmp++; if (len_err_count !== 32'd0) begin n_bad++; $display("FAIL corrupt_len_err: got %0d want 0", len_err_count); end
    endtask

    task automatic test_length();
        do_clr();
        send_frame(MAC, ET, 48'h4, 100, -1, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (len_err_count !== 32'd1) begin n_bad++; $display("FAIL short_len_err: got %0d want 1", len_err_count); end
        n_cmp++; if (frame_count !== 32'd1) begin n_bad++; $display("FAIL short_frames: got %0d want 1", frame_count); end
        n_cmp++; if (good_count !== 32'd0) begin n_bad++; $display("FAIL short_good: got %0d want 0", good_count); end
        send_frame(MAC, ET, 48'h5, LENGTH, -1, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (good_count !== 32'd1) begin n_bad++; $display("FAIL after_short_good: got %0d want 1", good_count); end
        send_frame(MAC, ET, 48'h6, LENGTH + 8, -1, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (len_err_count !== 32'd2) begin n_bad++; $display("FAIL long_len_err: got %0d want 2", len_err_count); end
        n_cmp++; if ({frame_count, good_count, data_err_count} !== {32'd3, 32'd1, 32'd0}) begin
            n_bad++; $display("FAIL long_counts: frame=%0d good=%0d data_err=%0d want 3 1 0", frame_count, good_count, data_err_count);
        end
    endtask

    task automatic test_user();
        do_clr();
        send_frame(MAC, ET, 48'h7, LENGTH, -1, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (user_err_count !== 32'd1) begin n_bad++; $display("FAIL user_err: got %0d want 1", user_err_count); end
        n_cmp++; if ({frame_count, good_count, len_err_count} !== {32'd1, 32'd0, 32'd0}) begin
            n_bad++; $display("FAIL user_counts: frame=%0d good=%0d len_err=%0d want 1 0 0", frame_count, good_count, len_err_count);
        end
    endtask

    task automatic test_drop();
        do_clr();
        stalled = 1'b0;
        send_frame(MAC, 16'h0800, 48'hDEAD, LENGTH, -1, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (drop_count !== 32'd1) begin n_bad++; $display("FAIL drop_type_count: got %0d want 1", drop_count); end
        n_cmp++; if (frame_count !== 32'd0) begin n_bad++; $display("FAIL drop_frames: got %0d want 0", frame_count); end
        n_cmp++; if (stalled !== 1'b0) begin n_bad++; $display("FAIL drop_tready_held: stalled=%0b want 0", stalled); end
        n_cmp++; if (last_src_mac !== 48'h7) begin n_bad++; $display("FAIL drop_src_kept: got %0h want 7", last_src_mac); end
        send_frame(BAD_MAC, ET, 48'hBEEF, LENGTH, 5, 8'hEE, 1'b0, 1'b0);
        n_cmp++; if (drop_count !== 32'd2) begin n_bad++; $display("FAIL drop_mac_count: got %0d want 2", drop_count); end
        n_cmp++; if ({synced, data_err_count, len_err_count} !== 65'd0) begin
            n_bad++; $display("FAIL drop_no_check: synced=%0b data_err=%0d len_err=%0d want 0 0 0", synced, data_err_count, len_err_count);
        end
    endtask

    task automatic test_reset_mid();
        send_hdr(MAC, ET, 48'h8);
        for (int i = 0; i < 200; i++) begin
            send_beat(next_byte, 1'b0, 1'b0, 1'b0);
            next_byte = next_byte + 8'd1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({rx_if.s_eth_hdr_ready, rx_if.s_eth_payload_axis_tready} !== 2'b00) begin
            n_bad++; $display("FAIL midrst_readies: hdr_ready=%0b tready=%0b want 0 0", rx_if.s_eth_hdr_ready, rx_if.s_eth_payload_axis_tready);
        end
        n_cmp++; if ({drop_count, frame_count, synced, last_src_mac} !== 113'd0) begin
            n_bad++; $display("FAIL midrst_state: drop=%0d frame=%0d synced=%0b src=%0h want 0 0 0 0", drop_count, frame_count, synced, last_src_mac);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(MAC, ET, 48'h9, LENGTH, -1, 8'h00, 1'b0, 1'b0);
        n_cmp++; if ({frame_count, good_count, len_err_count, data_err_count} !== {32'd1, 32'd1, 32'd0, 32'd0}) begin
            n_bad++; $display("FAIL midrst_next: frame=%0d good=%0d len=%0d data=%0d want 1 1 0 0", frame_count, good_count, len_err_count, data_err_count);
        end
    endtask

    task automatic test_gaps_clr();
        rand_gaps = 1'b1;
        do_clr();
        send_frame(MAC, ET, 48'hA, LENGTH, -1, 8'h00, 1'b0, 1'b0);
        send_frame(MAC, ET, 48'hB, LENGTH, -1, 8'h00, 1'b0, 1'b0);
        n_cmp++; if ({frame_count, good_count} !== {32'd2, 32'd2}) begin n_bad++; $display("FAIL gaps_counts: frame=%0d good=%0d want 2 2", frame_count, good_count); end
        send_frame(MAC, ET, 48'hC, LENGTH, 3, 8'h99, 1'b1, 1'b1);
        n_cmp++; if ({frame_count, good_count, data_err_count, user_err_count, synced} !== 129'd0) begin
            n_bad++; $display("FAIL clr_at_tlast: frame=%0d good=%0d data=%0d user=%0d synced=%0b want 0 0 0 0 0", frame_count, good_count, data_err_count, user_err_count, synced);
        end
        send_frame(MAC, ET, 48'hD, LENGTH, -1, 8'h00, 1'b0, 1'b0);
        n_cmp++; if ({frame_count, good_count} !== {32'd1, 32'd1}) begin n_bad++; $display("FAIL after_clr: frame=%0d good=%0d want 1 1", frame_count, good_count); end
        rand_gaps = 1'b0;
    endtask

    initial begin
        rx_if.s_eth_hdr_valid           = 1'b0;
        rx_if.s_eth_dest_mac            = '0;
        rx_if.s_eth_src_mac             = '0;
        rx_if.s_eth_type                = '0;
        rx_if.s_eth_payload_axis_tdata  = '0;
        rx_if.s_eth_payload_axis_tvalid = 1'b0;
        rx_if.s_eth_payload_axis_tlast  = 1'b0;
        rx_if.s_eth_payload_axis_tuser  = 1'b0;
        test_reset();
        test_good_frames();
        test_corrupt();
        test_length();
        test_user();
        test_drop();
        test_reset_mid();
        test_gaps_clr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
